// File: rtl/pipeline_hazard_scheduler_if.sv
// Bus between the pipeline datapath and the hazard scheduler.
// Inputs to the scheduler:
//   id_ex_memread, id_ex_rt, if_id_rs, if_id_rt   load-use detection
//   ex_branch_taken, id_jump                      redirect / squash
//   mdu_start, mdu_is_div, id_uses_hilo           MDU sequencing and HI/LO hazard
// Outputs from the scheduler:
//   pc_write, if_id_write, if_id_flush, id_ex_bubble    pipeline register controls
//   mdu_busy, mdu_done, mdu_overrun                     MDU status
//   stall_count                                         saturating stall counter
interface pipeline_hazard_scheduler_if;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        ex_branch_taken;
    logic        id_jump;
    logic        mdu_start;
    logic        mdu_is_div;
    logic        id_uses_hilo;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        mdu_busy;
    logic        mdu_done;
    logic        mdu_overrun;
    logic [15:0] stall_count;

    modport master (
        output id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
               ex_branch_taken, id_jump, mdu_start, mdu_is_div, id_uses_hilo,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               mdu_busy, mdu_done, mdu_overrun, stall_count
    );

    modport slave (
        input  id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
               ex_branch_taken, id_jump, mdu_start, mdu_is_div, id_uses_hilo,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               mdu_busy, mdu_done, mdu_overrun, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_scheduler.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline.
// Combines load-use detection, EX branch redirect, ID jump squash and a
// multi-cycle MDU busy sequencer into PC / IF/ID / ID/EX controls, and keeps
// a saturating count of stall cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipeline_hazard_scheduler_if.slave (see interface file)
module pipeline_hazard_scheduler #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_hazard_scheduler_if.slave  bus
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [CNT_W-1:0] LP_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic [15:0]      r_stall_count;

    logic w_load_use, w_hilo_hazard, w_busy;
    logic w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_bubble;

    assign w_busy        = (r_state == S_BUSY);
    assign w_load_use    = bus.id_ex_memread &
                           ((bus.id_ex_rt == bus.if_id_rs) | (bus.id_ex_rt == bus.if_id_rt));
    assign w_hilo_hazard = w_busy & bus.id_uses_hilo;

    // Branch wins over stalls: the instruction held in ID is wrong-path anyway.
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        if (bus.ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_hilo_hazard || w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end else if (bus.id_jump) begin
            w_if_id_flush  = 1'b1;
        end
    end

    // MDU sequencer next-state logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (bus.mdu_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = bus.mdu_is_div ? LP_DIV_LOAD : LP_MULT_LOAD;
                end
            end
            S_BUSY: begin
                if (bus.mdu_start) begin
                    w_overrun_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
            if (!w_pc_write && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.mdu_busy     = w_busy;
    assign bus.mdu_done     = r_done;
    assign bus.mdu_overrun  = r_overrun;
    assign bus.stall_count  = r_stall_count;
endmodule
